// File: rtl/uart_watch_pkg.sv
// Shared definitions for the UART command controller of the watch:
// FSM state encoding, command byte values, decoder one-hot bit positions
// and the default error reply byte.
package uart_watch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [7:0] CMD_MODE = 8'h4D;  // "M"
    localparam logic [7:0] CMD_RUN  = 8'h72;  // "r"
    localparam logic [7:0] CMD_CLR  = 8'h63;  // "c"
    localparam logic [7:0] CMD_UP   = 8'h75;  // "u"
    localparam logic [7:0] CMD_DN   = 8'h64;  // "d"

    localparam logic [7:0] ERR_CHAR_DEFAULT = 8'h3F;  // "?"

    // Bit positions inside the decoder's one-hot {mode, run, clr, up, dn, invalid}
    localparam int HOT_MODE = 5;
    localparam int HOT_RUN  = 4;
    localparam int HOT_CLR  = 3;
    localparam int HOT_UP   = 2;
    localparam int HOT_DN   = 1;
    localparam int HOT_INV  = 0;

endpackage

// File: rtl/uart_cmd_decode.sv
// Combinational command decoder: maps a received byte onto exactly one of
// {mode, run, clr, up, dn, invalid}.
module uart_cmd_decode
    import uart_watch_pkg::*;
(
    input  logic [7:0] cmd,
    output logic [5:0] hot
);

    // One-hot decode; anything that is not a known command is invalid
    always_comb begin
        hot = '0;
        case (cmd)
            CMD_MODE: hot[HOT_MODE] = 1'b1;
            CMD_RUN:  hot[HOT_RUN]  = 1'b1;
            CMD_CLR:  hot[HOT_CLR]  = 1'b1;
            CMD_UP:   hot[HOT_UP]   = 1'b1;
            CMD_DN:   hot[HOT_DN]   = 1'b1;
            default:  hot[HOT_INV]  = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: pops command bytes from an RX FIFO, applies them
// to the watch mode/run/clear/adjust controls, merges the debounced buttons
// and sends a reply byte on the TX FIFO.
// Optional macro UART_CMD_ECHO_EN: when defined, every valid command is
// echoed back; when undefined only invalid bytes produce an ERR_CHAR reply.
module uart_cmd_ctrl
    import uart_watch_pkg::*;
#(
    parameter logic [7:0] ERR_CHAR   = ERR_CHAR_DEFAULT,
    parameter int         TX_TIMEOUT = 1023
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_pop,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_data,
    input  logic       btn_mode,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       stpw_mode,
    output logic       run,
    output logic       clear,
    output logic       up,
    output logic       down,
    output logic       busy
);

    localparam int CW = $clog2(TX_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            stpw_mode_q, stpw_mode_d;
    logic            run_q, run_d;
    logic            clear_q, clear_d;
    logic            up_q, up_d;
    logic            down_q, down_d;

    logic [5:0]      hot;
    logic            exec_en;

    uart_cmd_decode u_decode (
        .cmd (cmd_q),
        .hot (hot)
    );

    // State, command and control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            wait_cnt_q  <= '0;
            stpw_mode_q <= 1'b0;
            run_q       <= 1'b0;
            clear_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            wait_cnt_q  <= wait_cnt_d;
            stpw_mode_q <= stpw_mode_d;
            run_q       <= run_d;
            clear_q     <= clear_d;
            up_q        <= up_d;
            down_q      <= down_d;
        end
    end

    // Command FSM: fetch a byte, execute it, then reply or give up after a TX stall
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        wait_cnt_d = wait_cnt_q;
        rx_pop     = 1'b0;
        tx_push    = 1'b0;
        tx_data    = '0;
        exec_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_empty && rst) begin
                    rx_pop  = 1'b1;
                    cmd_d   = rx_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec_en    = 1'b1;
                wait_cnt_d = '0;
`ifdef UART_CMD_ECHO_EN
                state_d    = RESP;
`else
                state_d    = hot[HOT_INV] ? RESP : IDLE;
`endif
            end
            RESP: begin
                if (!tx_full) begin
                    tx_push    = 1'b1;
`ifdef UART_CMD_ECHO_EN
                    tx_data    = hot[HOT_INV] ? ERR_CHAR : cmd_q;
`else
                    tx_data    = ERR_CHAR;
`endif
                    wait_cnt_d = '0;
                    state_d    = IDLE;
                end else if (wait_cnt_q == CW'(TX_TIMEOUT - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = DROP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            DROP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Merge buttons and the executing UART command; a coincident request on the
    // same control yields a single effect, pulses are never stretched
    always_comb begin
        logic mode_tgl;
        logic run_tgl;
        logic clr_req;
        logic up_req;
        logic dn_req;
        mode_tgl    = btn_mode  | (exec_en & hot[HOT_MODE]);
        run_tgl     = (btn_run   | (exec_en & hot[HOT_RUN])) & stpw_mode_q;
        clr_req     = (btn_clear | (exec_en & hot[HOT_CLR])) & stpw_mode_q & ~run_q;
        up_req      = (btn_up    | (exec_en & hot[HOT_UP]))  & ~stpw_mode_q;
        dn_req      = (btn_down  | (exec_en & hot[HOT_DN]))  & ~stpw_mode_q;
        stpw_mode_d = stpw_mode_q ^ mode_tgl;
        run_d       = run_q ^ run_tgl;
        clear_d     = clr_req & ~clear_q;
        up_d        = up_req  & ~up_q;
        down_d      = dn_req  & ~down_q;
    end

    assign stpw_mode = stpw_mode_q;
    assign run       = run_q;
    assign clear     = clear_q;
    assign up        = up_q;
    assign down      = down_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus a random
// command/button mix checked against a rule-level model of the watch controls.
module tb_uart_cmd_ctrl;

`ifdef UART_CMD_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_pop;
    logic       tx_full = 1'b0;
    logic       tx_push;
    logic [7:0] tx_data;
    logic       btn_mode = 1'b0, btn_run = 1'b0, btn_clear = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       stpw_mode, run, clear, up, down, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Observed activity
    logic [7:0] txq[$];
    int clr_cnt = 0, up_cnt = 0, dn_cnt = 0, consec = 0, up_cyc = -1;
    logic prev_clear = 1'b0, prev_up = 1'b0, prev_down = 1'b0;

    // Reference model state
    bit m_mode = 1'b0;
    bit m_run  = 1'b0;
    int exp_clr = 0, exp_up = 0, exp_dn = 0;
    logic [7:0] exp_txq[$];

    uart_cmd_ctrl dut (
        .clk(clk), .rst(rst),
        .rx_empty(rx_empty), .rx_data(rx_data), .rx_pop(rx_pop),
        .tx_full(tx_full), .tx_push(tx_push), .tx_data(tx_data),
        .btn_mode(btn_mode), .btn_run(btn_run), .btn_clear(btn_clear),
        .btn_up(btn_up), .btn_down(btn_down),
        .stpw_mode(stpw_mode), .run(run), .clear(clear), .up(up), .down(down),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record TX pushes and output pulses once per cycle, mid-cycle
    always @(negedge clk) begin
        #2;
        if (tx_push) txq.push_back(tx_data);
        if (clear) clr_cnt <= clr_cnt + 1;
        if (up) begin
            up_cnt <= up_cnt + 1;
            up_cyc <= cyc;
        end
        if (down) dn_cnt <= dn_cnt + 1;
        if ((clear && prev_clear) || (up && prev_up) || (down && prev_down)) consec <= consec + 1;
        prev_clear <= clear;
        prev_up    <= up;
        prev_down  <= down;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_byte(input logic [7:0] b);
        bit valid;
        valid = 1'b1;
        case (b)
            8'h4D: m_mode = !m_mode;
            8'h72: if (m_mode) m_run = !m_run;
            8'h63: if (m_mode && !m_run) exp_clr++;
            8'h75: if (!m_mode) exp_up++;
            8'h64: if (!m_mode) exp_dn++;
            default: valid = 1'b0;
        endcase
        if (!valid) exp_txq.push_back(8'h3F);
        else if (ECHO) exp_txq.push_back(b);
    endtask

    task automatic model_btn(input int which);
        case (which)
            0: m_mode = !m_mode;
            1: if (m_mode) m_run = !m_run;
            2: if (m_mode && !m_run) exp_clr++;
            3: if (!m_mode) exp_up++;
            default: if (!m_mode) exp_dn++;
        endcase
    endtask

    // Offer a byte on the RX FIFO until popped; returns in the EXEC cycle
    task automatic send_byte(input logic [7:0] b, output int pop_cyc);
        bit ok;
        ok = 1'b0;
        pop_cyc = -1;
        @(negedge clk);
        rx_empty = 1'b0;
        rx_data  = b;
        for (int i = 0; i < 2000; i++) begin
            #3;
            if (rx_pop) begin
                pop_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL rx_pop_wait: byte %h never popped, required a pop", b);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            #3;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL busy_wait: busy stuck at 1, required 0");
        end
    endtask

    task automatic press_btn(input int which);
        @(negedge clk);
        case (which)
            0: btn_mode  = 1'b1;
            1: btn_run   = 1'b1;
            2: btn_clear = 1'b1;
            3: btn_up    = 1'b1;
            default: btn_down = 1'b1;
        endcase
        @(negedge clk);
        btn_mode = 1'b0; btn_run = 1'b0; btn_clear = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx_empty = 1'b0;
        rx_data = 8'h4D;
        @(negedge clk);
        #3;
        total += 9;
        if (stpw_mode !== 1'b0) begin bad++; $display("[TB] FAIL reset_stpw_mode: got %b want 0", stpw_mode); end
        if (run !== 1'b0)       begin bad++; $display("[TB] FAIL reset_run: got %b want 0", run); end
        if (clear !== 1'b0)     begin bad++; $display("[TB] FAIL reset_clear: got %b want 0", clear); end
        if (up !== 1'b0)        begin bad++; $display("[TB] FAIL reset_up: got %b want 0", up); end
        if (down !== 1'b0)      begin bad++; $display("[TB] FAIL reset_down: got %b want 0", down); end
        if (rx_pop !== 1'b0)    begin bad++; $display("[TB] FAIL reset_rx_pop: got %b want 0", rx_pop); end
        if (tx_push !== 1'b0)   begin bad++; $display("[TB] FAIL reset_tx_push: got %b want 0", tx_push); end
        if (tx_data !== 8'h00)  begin bad++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
        if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rx_empty = 1'b1;
        rx_data = 8'h00;
        rst = 1'b1;
    endtask

    task automatic check_txq(input string name);
        total++;
        if (txq.size() != exp_txq.size()) begin
            bad++;
            $display("[TB] FAIL %s_tx_count: got %0d bytes want %0d", name, txq.size(), exp_txq.size());
        end else begin
            for (int i = 0; i < txq.size(); i++) begin
                total++;
                if (txq[i] !== exp_txq[i]) begin
                    bad++;
                    $display("[TB] FAIL %s_tx_byte%0d: got %h want %h", name, i, txq[i], exp_txq[i]);
                end
            end
        end
        txq.delete();
        exp_txq.delete();
    endtask

    task automatic test_sequence();
        logic [7:0] seq[6];
        bit         run_lit[6];
        int         pc;
        seq     = '{8'h4D, 8'h72, 8'h63, 8'h72, 8'h63, 8'h72};
        run_lit = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            model_byte(seq[i]);
            send_byte(seq[i], pc);
            wait_idle();
            total += 4;
            if (stpw_mode !== m_mode) begin bad++; $display("[TB] FAIL seq_mode%0d: got %b want %b", i, stpw_mode, m_mode); end
            if (run !== m_run)        begin bad++; $display("[TB] FAIL seq_run%0d: got %b want %b", i, run, m_run); end
            if (run !== run_lit[i])   begin bad++; $display("[TB] FAIL seq_run_lit%0d: got %b want %b", i, run, run_lit[i]); end
            if (clr_cnt != exp_clr)   begin bad++; $display("[TB] FAIL seq_clear%0d: got %0d pulses want %0d", i, clr_cnt, exp_clr); end
        end
        total++;
        if (clr_cnt != 1) begin bad++; $display("[TB] FAIL seq_clear_total: got %0d want 1", clr_cnt); end
        check_txq("seq");
    endtask

    task automatic test_invalid();
        int pc;
        bit m0, r0;
        int c0, u0, d0;
        m0 = stpw_mode; r0 = run; c0 = clr_cnt; u0 = up_cnt; d0 = dn_cnt;
        model_byte(8'h78);
        send_byte(8'h78, pc);
        wait_idle();
        total += 3;
        if (stpw_mode !== m0 || run !== r0) begin bad++; $display("[TB] FAIL inv_levels: got mode=%b run=%b want mode=%b run=%b", stpw_mode, run, m0, r0); end
        if (clr_cnt != c0 || up_cnt != u0 || dn_cnt != d0) begin bad++; $display("[TB] FAIL inv_pulses: got c/u/d delta %0d/%0d/%0d want 0/0/0", clr_cnt - c0, up_cnt - u0, dn_cnt - d0); end
        if (txq.size() != 1 || txq[0] !== 8'h3F) begin bad++; $display("[TB] FAIL inv_tx: got %0d bytes want one 3f", txq.size()); end
        check_txq("inv");
    endtask

    task automatic test_up();
        int pc, u0, d0;
        if (!m_mode) begin model_byte(8'h4D); send_byte(8'h4D, pc); wait_idle(); end
        model_byte(8'h4D);
        send_byte(8'h4D, pc);
        wait_idle();
        total += 2;
        if (stpw_mode !== 1'b0) begin bad++; $display("[TB] FAIL up_mode: got %b want 0", stpw_mode); end
        if (run !== m_run)      begin bad++; $display("[TB] FAIL up_run_kept: got %b want %b", run, m_run); end
        u0 = up_cnt;
        model_byte(8'h75);
        send_byte(8'h75, pc);
        wait_idle();
        repeat (3) @(negedge clk);
        #3;
        total += 3;
        if (up_cnt != u0 + 1)  begin bad++; $display("[TB] FAIL up_pulse_count: got %0d want 1", up_cnt - u0); end
        if (up_cyc != pc + 2)  begin bad++; $display("[TB] FAIL up_latency: got %0d cycles want 2", up_cyc - pc); end
        if (consec != 0)       begin bad++; $display("[TB] FAIL up_width: got %0d double pulses want 0", consec); end
        d0 = dn_cnt;
        model_byte(8'h64);
        send_byte(8'h64, pc);
        wait_idle();
        total++;
        if (dn_cnt != d0 + 1) begin bad++; $display("[TB] FAIL down_pulse: got %0d want 1", dn_cnt - d0); end
        model_byte(8'h4D);
        send_byte(8'h4D, pc);
        wait_idle();
        u0 = up_cnt;
        model_byte(8'h75);
        send_byte(8'h75, pc);
        wait_idle();
        repeat (3) @(negedge clk);
        #3;
        total++;
        if (up_cnt != u0) begin bad++; $display("[TB] FAIL up_in_stpw: got %0d pulses want 0", up_cnt - u0); end
        check_txq("up");
    endtask

    task automatic test_timeout();
        int pc, low;
        int n0;
        n0 = txq.size();
        low = -1;
        @(negedge clk);
        tx_full = 1'b1;
        send_byte(8'h78, pc);
        for (int i = 0; i < 1200; i++) begin
            #3;
            if (!busy) begin low = cyc; break; end
            @(negedge clk);
        end
        while (cyc < pc + 1100) @(negedge clk);
        #3;
        total += 2;
        if (low != pc + 1026) begin bad++; $display("[TB] FAIL timeout_idle_cycle: got %0d want %0d", low, pc + 1026); end
        if (txq.size() != n0) begin bad++; $display("[TB] FAIL timeout_no_push: got %0d pushes want 0", txq.size() - n0); end
        @(negedge clk);
        tx_full = 1'b0;
        txq.delete();
        exp_txq.delete();
        model_byte(8'h78);
        send_byte(8'h78, pc);
        wait_idle();
        check_txq("after_timeout");
    endtask

    task automatic test_btn_conflict();
        int pc;
        if (!m_mode) begin model_byte(8'h4D); send_byte(8'h4D, pc); wait_idle(); end
        if (m_run)   begin model_byte(8'h72); send_byte(8'h72, pc); wait_idle(); end
        model_byte(8'h72);
        send_byte(8'h72, pc);
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        wait_idle();
        total += 3;
        if (run !== 1'b1)       begin bad++; $display("[TB] FAIL btn_conflict_run: got %b want 1", run); end
        if (run !== m_run)      begin bad++; $display("[TB] FAIL btn_conflict_model: got %b want %b", run, m_run); end
        if (stpw_mode !== 1'b1) begin bad++; $display("[TB] FAIL btn_conflict_mode: got %b want 1", stpw_mode); end
        check_txq("btn_conflict");
    endtask

    task automatic test_random();
        int sel, w, pc, stall;
        logic [7:0] b;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                w = $urandom_range(0, 4);
                press_btn(w);
                model_btn(w);
            end else begin
                case ($urandom_range(0, 6))
                    0: b = 8'h4D;
                    1: b = 8'h72;
                    2: b = 8'h63;
                    3: b = 8'h75;
                    4: b = 8'h64;
                    default: b = 8'($urandom);
                endcase
                stall = $urandom_range(0, 12);
                model_byte(b);
                @(negedge clk);
                tx_full = (stall != 0);
                send_byte(b, pc);
                repeat (stall) @(negedge clk);
                tx_full = 1'b0;
                wait_idle();
            end
            total += 2;
            if (stpw_mode !== m_mode) begin bad++; $display("[TB] FAIL rand_mode%0d: got %b want %b", it, stpw_mode, m_mode); end
            if (run !== m_run)        begin bad++; $display("[TB] FAIL rand_run%0d: got %b want %b", it, run, m_run); end
        end
        repeat (3) @(negedge clk);
        #3;
        total += 4;
        if (clr_cnt != exp_clr) begin bad++; $display("[TB] FAIL rand_clear: got %0d want %0d", clr_cnt, exp_clr); end
        if (up_cnt != exp_up)   begin bad++; $display("[TB] FAIL rand_up: got %0d want %0d", up_cnt, exp_up); end
        if (dn_cnt != exp_dn)   begin bad++; $display("[TB] FAIL rand_down: got %0d want %0d", dn_cnt, exp_dn); end
        if (consec != 0)        begin bad++; $display("[TB] FAIL rand_pulse_width: got %0d double pulses want 0", consec); end
        check_txq("rand");
    endtask

    task automatic test_reset_mid();
        int pc;
        if (m_mode) begin model_byte(8'h4D); send_byte(8'h4D, pc); wait_idle(); end
        txq.delete();
        exp_txq.delete();
        @(negedge clk);
        tx_full = 1'b0;
        send_byte(8'h4D, pc);
        rst = 1'b0;
        #1;
        total += 4;
        if (stpw_mode !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_mode: got %b want 0", stpw_mode); end
        if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
        if (tx_push !== 1'b0)   begin bad++; $display("[TB] FAIL rstmid_tx_push: got %b want 0", tx_push); end
        if (run !== 1'b0)       begin bad++; $display("[TB] FAIL rstmid_run: got %b want 0", run); end
        m_mode = 1'b0;
        m_run  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        total += 3;
        if (stpw_mode !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_mode_after: got %b want 0", stpw_mode); end
        if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL rstmid_busy_after: got %b want 0", busy); end
        if (txq.size() != 0)    begin bad++; $display("[TB] FAIL rstmid_no_tx: got %0d pushes want 0", txq.size()); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_invalid();
        test_up();
        test_timeout();
        test_btn_conflict();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- ERR_CHAR, default 8'h3F ("?"): byte returned on TX for an unrecognised command.
- TX_TIMEOUT, default 1023: maximum number of cycles to wait on tx_full before the response is dropped.

REQ-002 The block SHALL have these ports:
- clk in 1: the single clock; all state changes on its rising edge.
- rst in 1: asynchronous, active-low reset.
- rx_empty in 1: RX FIFO empty.
- rx_data in 8: RX FIFO head byte, valid whenever rx_empty=0 (show-ahead).
- rx_pop out 1: pops the RX FIFO head.
- tx_full in 1: TX FIFO full.
- tx_push out 1: pushes tx_data into the TX FIFO.
- tx_data out 8: TX byte.
- btn_mode, btn_run, btn_clear, btn_up, btn_down in 1 each: debounced, one-cycle button pulses.
- stpw_mode out 1: level; 1 = stopwatch, 0 = clock.
- run out 1: level; stopwatch running.
- clear out 1: one-cycle stopwatch clear pulse.
- up, down out 1 each: one-cycle clock-adjust pulses.
- busy out 1: high whenever the FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have exactly four states, IDLE, EXEC, RESP and DROP, and no other states.
REQ-004 IDLE:
- When rx_empty=0, rx_pop SHALL be 1 for that one cycle and rx_data SHALL be latched into cmd_q.
- The next state SHALL be EXEC.
- rx_pop SHALL never be asserted outside IDLE.
REQ-005 EXEC SHALL last one cycle and decode cmd_q as follows:
- "M": toggle stpw_mode.
- "r": toggle run, only when stpw_mode=1.
- "c": pulse clear, only when stpw_mode=1 and run=0.
- "u": pulse up, only when stpw_mode=0.
- "d": pulse down, only when stpw_mode=0.
- Any other byte: invalid.
REQ-006 A recognised command whose mode or run condition is false SHALL be ignored without error, counted as valid.
REQ-007 Effects decided in EXEC SHALL be registered, so that levels change and pulses are high during the cycle after EXEC.
REQ-008 Byte-to-effect latency SHALL be 2 cycles: pop cycle t, effect visible in cycle t+2.
REQ-009 After EXEC the next state SHALL be:
- RESP, if the command is invalid, or if UART_CMD_ECHO_EN is defined;
- IDLE, otherwise.
REQ-010 RESP:
- While tx_full=0, tx_push=1 for exactly one cycle, with tx_data = cmd_q for a valid command or ERR_CHAR for an invalid one, then go to IDLE.
- While tx_full=1, the block SHALL wait and count the waited cycles.
REQ-011 When the wait count in RESP reaches TX_TIMEOUT, the FSM SHALL go to DROP for one cycle with no push, then to IDLE.
REQ-012 Button pulses SHALL act in any state under the same mode and run conditions as the UART commands, with effect registered (1-cycle latency).
REQ-013 If a button and a UART EXEC target the same output in the same cycle, the button SHALL win and the UART effect SHALL be discarded; the UART response is still sent.
REQ-014 Toggling stpw_mode SHALL NOT alter run.
REQ-015 clear, up and down SHALL never be high for two consecutive cycles.

Reset
REQ-016 On rst=0, without waiting for clk, the block SHALL set state=IDLE and the following outputs and registers to 0: stpw_mode, run, clear, up, down, rx_pop, tx_push, tx_data, busy, cmd_q and the timeout counter.
REQ-017 A reset asserted mid-command SHALL discard that command; the byte already popped is lost and no response is sent.

Configuration
REQ-018 Macro UART_CMD_ECHO_EN:
- Defined: every popped byte SHALL produce exactly one TX byte (echo for valid, ERR_CHAR for invalid).
- Undefined: only invalid bytes SHALL produce TX bytes, and the echo path SHALL be absent from the logic.

Structure
REQ-019 The shared package uart_watch_pkg SHALL hold:
- the FSM state enum;
- the command byte constants CMD_MODE="M", CMD_RUN="r", CMD_CLR="c", CMD_UP="u", CMD_DN="d";
- the ERR_CHAR default.
REQ-020 The one sub-module SHALL be uart_cmd_decode: combinational, cmd byte in, one-hot {mode, run, clr, up, dn, invalid} out.

Verification
REQ-021 A bench SHALL cover these directed scenarios:
- "M","r","c","r","c","r" sent from reset → stpw_mode=1; run 1,1,0,0,1 after each of the last five bytes; exactly one clear pulse (after the 5th byte); with ECHO_EN, TX carries the six bytes in order.
- "x" sent → tx_data=8'h3F pushed once; no output change; same result with ECHO_EN undefined.
- "u" with stpw_mode=0 → up high for exactly 1 cycle, 2 cycles after rx_pop; "u" with stpw_mode=1 → no pulse.
- tx_full held at 1 for 1100 cycles during RESP → no push; DROP entered after 1023 cycles; the next RX byte is processed normally.
- btn_run and a UART "r" EXEC in the same cycle, stopwatch mode, run=0 → run=1 (the button wins; the UART toggle is discarded).
- rst asserted in EXEC of "M" → stpw_mode=0, no TX push, busy=0 immediately.
